operand_scoreboard: RTL and testbench

//  Parametrised operand-read and hazard unit for the ID stage, replacing ad-hoc per-operand forwarding.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/operand_fwd_mux.sv | 37 +++
 rtl/operand_scoreboard.sv | 134 +++++++++++++
 tb/tb_operand_scoreboard.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants.
//   XLEN, NREG       : datapath width and architectural register count
//   LAT_W            : width of producer-latency fields and scoreboard counters
//   LAT_*            : issue-to-forwarding-tap latency of each producer class
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int LAT_W = 3;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 3;
  localparam int LAT_DIV  = 7;
  localparam int LAT_FP   = 4;

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority operand-select mux for one source operand.
// Ports:
//   addr      in   source register address
//   rf_data   in   register-file read data for this operand
//   fwd_we    in   per-tap result-valid flags
//   fwd_addr  in   per-tap destination addresses, tap 0 in LSBs
//   fwd_data  in   per-tap result data, tap 0 in LSBs
//   data      out  resolved operand value
// Register 0 reads as zero; otherwise the lowest-index (youngest) matching tap
// wins over older taps and the register file.
module operand_fwd_mux #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NFWD = 3
) (
  input  logic [AW-1:0]        addr,
  input  logic [XLEN-1:0]      rf_data,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic [XLEN-1:0]      data
);

  always_comb begin
    data = rf_data;
    // Walk from oldest to youngest so the youngest match is the last write.
    for (int j = NFWD - 1; j >= 0; j--) begin
      if (fwd_we[j] && (fwd_addr[j*AW +: AW] == addr)) begin
        data = fwd_data[j*XLEN +: XLEN];
      end
    end
    if (addr == '0) begin
      data = '0;
    end
  end

endmodule

// File: rtl/operand_scoreboard.sv
// ID-stage operand read and hazard unit.
// Tracks in-flight destinations with a pending bit and latency countdown per
// register, resolves operands from forwarding taps or the register file, and
// stalls issue on RAW-not-ready and WAW-reorder hazards.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   iss_valid     ID holds a decoded instruction
//   iss_rs_used   per-operand read enable
//   iss_rs_addr   source addresses, operand 0 in LSBs
//   iss_rd_we     instruction writes a destination
//   iss_rd        destination register
//   iss_lat       cycles from issue until result appears on a tap (>=1)
//   flush         kill the instruction in ID
//   rf_rdata      register-file read data per operand
//   fwd_we/addr/data  forwarding taps, 0 = youngest, NFWD-1 = writeback
//   opd_data      resolved operands (combinational)
//   stall         hold IF/ID, bubble into EX (combinational)
//   iss_fire      instruction accepted this cycle (combinational)
module operand_scoreboard #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREG  = riscv_pkg::NREG,
  parameter int NRS   = 2,
  parameter int NFWD  = 3,
  parameter int LAT_W = riscv_pkg::LAT_W,
  parameter int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic [NRS-1:0]       iss_rs_used,
  input  logic [NRS*AW-1:0]    iss_rs_addr,
  input  logic                 iss_rd_we,
  input  logic [AW-1:0]        iss_rd,
  input  logic [LAT_W-1:0]     iss_lat,
  input  logic                 flush,
  input  logic [NRS*XLEN-1:0]  rf_rdata,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic [NRS*XLEN-1:0]  opd_data,
  output logic                 stall,
  output logic                 iss_fire
);

  import riscv_pkg::*;

  logic [NREG-1:0]  pending;
  logic [LAT_W-1:0] cnt [NREG];

  logic [NRS-1:0]   raw;
  logic [NRS-1:0]   orphan;
  logic             waw;
  logic [LAT_W-1:0] lat_m1;
  logic [AW-1:0]    wb_addr;
  logic             wb_retire;

  assign lat_m1    = iss_lat - LAT_W'(1);
  assign wb_addr   = fwd_addr[(NFWD-1)*AW +: AW];
  assign wb_retire = fwd_we[NFWD-1] && (wb_addr != '0);

  // orphan flags a ready-but-not-retired operand with no tap carrying it,
  // which would silently read a stale register-file value.
  always_comb begin
    raw    = '0;
    orphan = '0;
    for (int i = 0; i < NRS; i++) begin
      if (iss_rs_used[i] && (iss_rs_addr[i*AW +: AW] != '0) &&
          pending[iss_rs_addr[i*AW +: AW]]) begin
        if (cnt[iss_rs_addr[i*AW +: AW]] != '0) begin
          raw[i] = 1'b1;
        end else begin
          orphan[i] = 1'b1;
          for (int j = 0; j < NFWD; j++) begin
            if (fwd_we[j] && (fwd_addr[j*AW +: AW] == iss_rs_addr[i*AW +: AW])) begin
              orphan[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  // A younger write may land no earlier than the older one in flight.
  assign waw = iss_rd_we && pending[iss_rd] && (cnt[iss_rd] > lat_m1);

  assign stall    = !rst && iss_valid && ((|raw) || waw);
  assign iss_fire = !rst && iss_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      // Entry 0 is never written, so x0 can never look pending.
      for (int r = 1; r < NREG; r++) begin
        if (iss_fire && iss_rd_we && (iss_rd == AW'(r))) begin
          pending[r] <= 1'b1;
          cnt[r]     <= lat_m1;
        end else begin
          if (cnt[r] != '0) begin
            cnt[r] <= cnt[r] - LAT_W'(1);
          end
          if (wb_retire && (wb_addr == AW'(r))) begin
            pending[r] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && iss_valid) begin
      assert (orphan == '0);
    end
  end

  for (genvar i = 0; i < NRS; i++) begin : g_opd
    operand_fwd_mux #(
      .XLEN (XLEN),
      .AW   (AW),
      .NFWD (NFWD)
    ) u_mux (
      .addr     (iss_rs_addr[i*AW +: AW]),
      .rf_data  (rf_rdata[i*XLEN +: XLEN]),
      .fwd_we   (fwd_we),
      .fwd_addr (fwd_addr),
      .fwd_data (fwd_data),
      .data     (opd_data[i*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_operand_scoreboard.sv
// Directed self-checking bench for operand_scoreboard (default parameters).
module tb_operand_scoreboard;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NRS   = 2;
  localparam int NFWD  = 3;
  localparam int LAT_W = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 iss_valid;
  logic [NRS-1:0]       iss_rs_used;
  logic [NRS*AW-1:0]    iss_rs_addr;
  logic                 iss_rd_we;
  logic [AW-1:0]        iss_rd;
  logic [LAT_W-1:0]     iss_lat;
  logic                 flush;
  logic [NRS*XLEN-1:0]  rf_rdata;
  logic [NFWD-1:0]      fwd_we;
  logic [NFWD*AW-1:0]   fwd_addr;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [NRS*XLEN-1:0]  opd_data;
  logic                 stall;
  logic                 iss_fire;

  operand_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .iss_valid   (iss_valid),
    .iss_rs_used (iss_rs_used),
    .iss_rs_addr (iss_rs_addr),
    .iss_rd_we   (iss_rd_we),
    .iss_rd      (iss_rd),
    .iss_lat     (iss_lat),
    .flush       (flush),
    .rf_rdata    (rf_rdata),
    .fwd_we      (fwd_we),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .opd_data    (opd_data),
    .stall       (stall),
    .iss_fire    (iss_fire)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    iss_valid   = 1'b0;
    iss_rs_used = '0;
    iss_rs_addr = '0;
    iss_rd_we   = 1'b0;
    iss_rd      = '0;
    iss_lat     = 3'd1;
    flush       = 1'b0;
    rf_rdata    = {32'h2222_2222, 32'h1111_1111};
    fwd_we      = '0;
    fwd_addr    = '0;
    fwd_data    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] rd, input logic [LAT_W-1:0] lat,
                       input logic [1:0] used, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    iss_valid   = 1'b1;
    iss_rd_we   = (rd != '0);
    iss_rd      = rd;
    iss_lat     = lat;
    iss_rs_used = used;
    iss_rs_addr = {a1, a0};
  endtask

  task automatic tap(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    fwd_we[j]              = 1'b1;
    fwd_addr[j*AW +: AW]   = a;
    fwd_data[j*XLEN +: XLEN] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("reset_pending", 64'(dut.pending), 64'h0);
    chk("reset_stall", 64'(stall), 64'h0);

    // 1: ALU lat 1 back-to-back with tap0 forwarding
    issue(5'd5, 3'd1, 2'b00, 5'd0, 5'd0);
    settle();
    chk("t1_add5_fire", 64'(iss_fire), 64'h1);
    tick();
    idle();
    issue(5'd6, 3'd1, 2'b11, 5'd5, 5'd5);
    tap(0, 5'd5, 32'h11);
    settle();
    chk("t1_stall", 64'(stall), 64'h0);
    chk("t1_fire", 64'(iss_fire), 64'h1);
    chk("t1_opd0", 64'(opd_data[31:0]), 64'h11);
    chk("t1_opd1", 64'(opd_data[63:32]), 64'h11);
    tick();
    do_reset();

    // 2: load lat 2 -> one bubble, then forward from tap1
    issue(5'd7, 3'd2, 2'b00, 5'd0, 5'd0);
    settle();
    chk("t2_lw_fire", 64'(iss_fire), 64'h1);
    tick();
    idle();
    issue(5'd9, 3'd1, 2'b01, 5'd7, 5'd0);
    settle();
    chk("t2_bubble_stall", 64'(stall), 64'h1);
    chk("t2_bubble_fire", 64'(iss_fire), 64'h0);
    tick();
    tap(1, 5'd7, 32'hDEAD);
    settle();
    chk("t2_after_stall", 64'(stall), 64'h0);
    chk("t2_after_fire", 64'(iss_fire), 64'h1);
    chk("t2_opd0", 64'(opd_data[31:0]), 64'hDEAD);
    tick();
    do_reset();

    // 3: DIV x8 lat 7, one idle cycle, then ADDI x8 lat 1 -> WAW holds until cnt reaches 0
    issue(5'd8, 3'd7, 2'b00, 5'd0, 5'd0);
    settle();
    chk("t3_div_fire", 64'(iss_fire), 64'h1);
    tick();
    idle();
    tick();
    issue(5'd8, 3'd1, 2'b00, 5'd0, 5'd0);
    settle();
    stalls = 0;
    while (stall && stalls < 20) begin
      stalls++;
      tick();
      settle();
    end
    chk("t3_waw_stall_cycles", 64'(stalls), 64'd5);
    chk("t3_addi_fire", 64'(iss_fire), 64'h1);
    tick();
    idle();
    chk("t3_pending8_set", 64'(dut.pending[8]), 64'h1);
    tap(2, 5'd8, 32'h0808);
    tick();
    idle();
    chk("t3_pending8_retired", 64'(dut.pending[8]), 64'h0);
    do_reset();

    // 4: forwarding priority and x0
    iss_valid   = 1'b1;
    iss_rs_used = 2'b11;
    iss_rs_addr = {5'd0, 5'd9};
    tap(0, 5'd9, 32'hA);
    tap(1, 5'd0, 32'h55);
    tap(2, 5'd9, 32'hB);
    settle();
    chk("t4_tap0_wins", 64'(opd_data[31:0]), 64'hA);
    chk("t4_x0_zero", 64'(opd_data[63:32]), 64'h0);
    chk("t4_fire", 64'(iss_fire), 64'h1);
    fwd_we[0] = 1'b0;
    settle();
    chk("t4_tap2_only", 64'(opd_data[31:0]), 64'hB);
    fwd_we = '0;
    settle();
    chk("t4_regfile", 64'(opd_data[31:0]), 64'h1111_1111);
    tick();
    do_reset();

    // 5: flush suppresses the set; retire + re-issue of same register keeps it pending
    issue(5'd10, 3'd3, 2'b00, 5'd0, 5'd0);
    flush = 1'b1;
    settle();
    chk("t5_flush_fire", 64'(iss_fire), 64'h0);
    chk("t5_flush_stall", 64'(stall), 64'h0);
    tick();
    idle();
    chk("t5_pending10", 64'(dut.pending[10]), 64'h0);
    issue(5'd0, 3'd1, 2'b01, 5'd10, 5'd0);
    settle();
    chk("t5_x10_no_stall", 64'(stall), 64'h0);
    tick();
    idle();
    issue(5'd11, 3'd1, 2'b00, 5'd0, 5'd0);
    tick();
    idle();
    issue(5'd11, 3'd2, 2'b00, 5'd0, 5'd0);
    tap(2, 5'd11, 32'h1111);
    settle();
    chk("t5_reissue_fire", 64'(iss_fire), 64'h1);
    tick();
    idle();
    chk("t5_pending11", 64'(dut.pending[11]), 64'h1);
    issue(5'd0, 3'd1, 2'b01, 5'd11, 5'd0);
    settle();
    chk("t5_x11_raw_stall", 64'(stall), 64'h1);
    tick();
    do_reset();

    // 6: reset with four producers in flight
    issue(5'd12, 3'd7, 2'b00, 5'd0, 5'd0);
    tick();
    issue(5'd13, 3'd7, 2'b00, 5'd0, 5'd0);
    tick();
    issue(5'd14, 3'd5, 2'b00, 5'd0, 5'd0);
    tick();
    issue(5'd15, 3'd4, 2'b00, 5'd0, 5'd0);
    tick();
    idle();
    chk("t6_four_pending", 64'(dut.pending), 64'h0000_F000);
    issue(5'd0, 3'd1, 2'b11, 5'd12, 5'd13);
    settle();
    chk("t6_pre_rst_stall", 64'(stall), 64'h1);
    rst = 1'b1;
    tap(0, 5'd12, 32'h77);
    settle();
    chk("t6_rst_stall", 64'(stall), 64'h0);
    chk("t6_rst_fire", 64'(iss_fire), 64'h0);
    chk("t6_rst_opd0", 64'(opd_data[31:0]), 64'h77);
    chk("t6_rst_opd1", 64'(opd_data[63:32]), 64'h2222_2222);
    tick();
    rst = 1'b0;
    fwd_we = '0;
    settle();
    chk("t6_cleared", 64'(dut.pending), 64'h0);
    chk("t6_post_stall", 64'(stall), 64'h0);
    chk("t6_post_fire", 64'(iss_fire), 64'h1);
    tick();
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
